// File: rtl/memory_responder_pkg.sv
// Shared types and widths for the memory responder slice.
package memory_package;

    localparam int WORD_WIDTH  = 32;
    localparam int COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } responderState_t;

endpackage

// File: rtl/memory_responder_array.sv
// Single-port synchronous word RAM: one read or one write per cycle, one-cycle read latency.
module memory_array
    import memory_package::*;
#(
    parameter int DEPTH = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clockIn,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    input  logic [WORD_WIDTH-1:0] writeData,
    output logic [WORD_WIDTH-1:0] readData
);

    logic [WORD_WIDTH-1:0] storage [DEPTH];

    // readData only moves on an explicit read so it survives idle cycles.
    always_ff @(posedge clockIn) begin
        if (writeEnable) begin
            storage[address] <= writeData;
        end else if (readEnable) begin
            readData <= storage[address];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Responder end of the pipeline memory handshake: fixed-latency load/store with range checking.
module memory_responder
    import memory_package::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic                  clockIn,
    input  logic                  resetIn,
    input  logic [31:0]           addressIn,
    input  logic [WORD_WIDTH-1:0] valueIn,
    input  logic                  loadIn,
    input  logic                  storeIn,
    output logic [WORD_WIDTH-1:0] valueOut,
    output logic                  readyOut,
    output logic                  errorOut
);

    localparam int ADDR_W = $clog2(DEPTH);

    responderState_t       state;
    logic [COUNT_WIDTH-1:0] counter;
    logic [ADDR_W-1:0]     indexLatched;
    logic [WORD_WIDTH-1:0] valueLatched;
    logic                  loadLatched;
    logic                  storeLatched;
    logic                  errorLatched;
    logic [WORD_WIDTH-1:0] valueHold;

    logic [32:0]           offset;
    logic [29:0]           wordIndex;
    logic                  requestNow;
    logic                  faultNow;
    logic                  ramWrite;
    logic                  ramRead;
    logic [ADDR_W-1:0]     ramAddress;
    logic [WORD_WIDTH-1:0] ramData;

    // Bit 32 of the 33-bit difference is the borrow, flagging address < BASE.
    assign offset     = {1'b0, addressIn} - {1'b0, BASE};
    assign wordIndex  = offset[31:2];
    assign requestNow = loadIn | storeIn;
    assign faultNow   = offset[32] | ({2'b00, wordIndex} >= 32'(DEPTH)) | (loadIn & storeIn);

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (requestNow) begin
                        counter <= COUNT_WIDTH'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? RESPOND : BUSY;
                    end
                end
                BUSY: begin
                    counter <= counter - 1'b1;
                    if (counter == COUNT_WIDTH'(1)) begin
                        state <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (state == IDLE && requestNow) begin
            indexLatched <= wordIndex[ADDR_W-1:0];
            valueLatched <= valueIn;
            loadLatched  <= loadIn;
            storeLatched <= storeIn;
            errorLatched <= faultNow;
        end
    end

    // The read is issued one cycle before RESPOND; with LATENCY=1 that is the accepting cycle itself.
    assign ramRead = (LATENCY == 1)
                   ? (state == IDLE && loadIn && !faultNow)
                   : (state == BUSY && counter == COUNT_WIDTH'(1) && loadLatched && !errorLatched);
    assign ramWrite   = (state == RESPOND) && storeLatched && !errorLatched && !resetIn;
    assign ramAddress = (state == IDLE) ? wordIndex[ADDR_W-1:0] : indexLatched;

    memory_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clockIn    (clockIn),
        .address    (ramAddress),
        .writeEnable(ramWrite),
        .readEnable (ramRead),
        .writeData  (valueLatched),
        .readData   (ramData)
    );

    // valueOut selects among registered sources only; valueHold keeps the last response.
    always_comb begin
        valueOut = valueHold;
        if (state == RESPOND && loadLatched) begin
            valueOut = errorLatched ? '0 : ramData;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            valueHold <= '0;
        end else if (state == RESPOND) begin
            valueHold <= valueOut;
        end
    end

    assign readyOut = (state == RESPOND);
    assign errorOut = (state == RESPOND) && errorLatched;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances covering LATENCY=2, LATENCY=1 and a non-zero BASE.
module tb_memory_responder;

    logic        clk;
    logic        rst      [3];
    logic [31:0] addr     [3];
    logic [31:0] val      [3];
    logic        ld       [3];
    logic        st       [3];
    logic [31:0] valueOut [3];
    logic        readyOut [3];
    logic        errorOut [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_responder #(.DEPTH(1024), .LATENCY(2), .BASE(32'h0000_0000)) dut0 (
        .clockIn(clk), .resetIn(rst[0]), .addressIn(addr[0]), .valueIn(val[0]),
        .loadIn(ld[0]), .storeIn(st[0]), .valueOut(valueOut[0]),
        .readyOut(readyOut[0]), .errorOut(errorOut[0]));

    memory_responder #(.DEPTH(1024), .LATENCY(1), .BASE(32'h0000_0000)) dut1 (
        .clockIn(clk), .resetIn(rst[1]), .addressIn(addr[1]), .valueIn(val[1]),
        .loadIn(ld[1]), .storeIn(st[1]), .valueOut(valueOut[1]),
        .readyOut(readyOut[1]), .errorOut(errorOut[1]));

    memory_responder #(.DEPTH(1024), .LATENCY(2), .BASE(32'h0000_1000)) dut2 (
        .clockIn(clk), .resetIn(rst[2]), .addressIn(addr[2]), .valueIn(val[2]),
        .loadIn(ld[2]), .storeIn(st[2]), .valueOut(valueOut[2]),
        .readyOut(readyOut[2]), .errorOut(errorOut[2]));

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at the negedge of the accepting cycle; returns at the negedge of the RESPOND cycle.
    task automatic access(input int d, input logic l, input logic s, input logic [31:0] a,
                          input logic [31:0] v, input int expLat, input logic [31:0] expVal,
                          input logic expErr, input string tag);
        int n;
        ld[d] = l; st[d] = s; addr[d] = a; val[d] = v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!readyOut[d] && n < 20);
        ld[d] = 1'b0; st[d] = 1'b0;
        chk({tag, "_ready"}, 32'(readyOut[d]), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(expLat));
        chk({tag, "_error"}, 32'(errorOut[d]), 32'(expErr));
        chk({tag, "_value"}, valueOut[d], expVal);
    endtask

    task automatic step(input int d, input logic l, input logic s, input logic [31:0] a,
                        input logic [31:0] v, input int expLat, input logic [31:0] expVal,
                        input logic expErr, input string tag);
        @(negedge clk);
        access(d, l, s, a, v, expLat, expVal, expErr, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; addr[i] = '0; val[i] = '0; ld[i] = 1'b0; st[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(readyOut[i]), 32'd0);
            chk("reset_error", 32'(errorOut[i]), 32'd0);
            chk("reset_value", valueOut[i], 32'd0);
            rst[i] = 1'b0;
        end

        // LATENCY=2, BASE=0
        step(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, "st10");
        step(0, 1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "ld10");
        @(negedge clk);
        chk("pulse_width", 32'(readyOut[0]), 32'd0);
        chk("value_hold", valueOut[0], 32'hDEAD_BEEF);
        step(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 2, 32'hDEAD_BEEF, 1'b0, "st20");
        step(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 2, 32'h0, 1'b1, "both20");
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h0BAD_F00D, 1'b0, "ld20");
        step(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111, 2, 32'h0BAD_F00D, 1'b0, "st30a");

        // Reset while the store to 0x30 is in BUSY
        @(negedge clk);
        ld[0] = 1'b0; st[0] = 1'b1; addr[0] = 32'h30; val[0] = 32'hCAFE_F00D;
        @(negedge clk);
        rst[0] = 1'b1; st[0] = 1'b0;
        @(negedge clk);
        chk("rst_busy_ready", 32'(readyOut[0]), 32'd0);
        chk("rst_busy_error", 32'(errorOut[0]), 32'd0);
        chk("rst_busy_value", valueOut[0], 32'd0);
        rst[0] = 1'b0;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 2, 32'h1111_1111, 1'b0, "ld30_post_rst");
        step(0, 1'b0, 1'b1, 32'h30, 32'hA5A5_A5A5, 2, 32'h1111_1111, 1'b0, "st30b");
        step(0, 1'b1, 1'b0, 32'h33, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, "ld33");

        // LATENCY=1, back-to-back store then load
        step(1, 1'b0, 1'b1, 32'h0, 32'h5A5A_0001, 1, 32'h0, 1'b0, "l1_st0");
        step(1, 1'b1, 1'b0, 32'h0, 32'h0, 1, 32'h5A5A_0001, 1'b0, "l1_ld0");

        // BASE=0x1000 range checks
        step(2, 1'b0, 1'b1, 32'h1FFC, 32'h7777_8888, 2, 32'h0, 1'b0, "b_st1ffc");
        step(2, 1'b0, 1'b1, 32'h1000, 32'h1357_2468, 2, 32'h0, 1'b0, "b_st1000");
        step(2, 1'b1, 1'b0, 32'h0FFC, 32'h0, 2, 32'h0, 1'b1, "b_ld0ffc");
        step(2, 1'b1, 1'b0, 32'h2000, 32'h0, 2, 32'h0, 1'b1, "b_ld2000");
        step(2, 1'b0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 2, 32'h0, 1'b1, "b_st2000");
        step(2, 1'b1, 1'b0, 32'h1FFC, 32'h0, 2, 32'h7777_8888, 1'b0, "b_ld1ffc");
        step(2, 1'b1, 1'b0, 32'h1000, 32'h0, 2, 32'h1357_2468, 1'b0, "b_ld1000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, storage size in 32-bit words (power of two, >= 2).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to readyOut (1..15).
REQ-003 SHALL have parameter BASE, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clockIn  input  1  rising-edge clock.
REQ-005 resetIn  input  1  synchronous active-high reset.
REQ-006 addressIn  input  32  byte address of the request.
REQ-007 valueIn  input  32  store data.
REQ-008 loadIn  input  1  load request.
REQ-009 storeIn  input  1  store request.
REQ-010 valueOut  output  32  load result, registered.
REQ-011 readyOut  output  1  one-cycle completion pulse.
REQ-012 errorOut  output  1  one-cycle fault flag, coincident with readyOut.

Function
REQ-013 SHALL implement the responder end of the pipeline memory handshake: the initiator holds address, value, load and store stable until it samples readyOut high, then drops or changes them in the next cycle.
REQ-014 SHALL use states IDLE, BUSY and RESPOND.
REQ-015 IDLE: when loadIn or storeIn is high, SHALL latch addressIn, valueIn, loadIn and storeIn, load the counter with LATENCY-1, and move to RESPOND if LATENCY=1, otherwise to BUSY.
REQ-016 BUSY: SHALL decrement the counter each cycle and move to RESPOND when it reaches 1.
REQ-017 RESPOND: SHALL drive readyOut high for exactly one cycle, then return to IDLE.
REQ-018 readyOut SHALL rise exactly LATENCY cycles after the accepting IDLE cycle.
REQ-019 Request inputs SHALL be ignored in BUSY and RESPOND.
REQ-020 A request present in the cycle after RESPOND SHALL be accepted (back-to-back requests), giving a throughput of one access per LATENCY+1 cycles.
REQ-021 Word index SHALL be (address - BASE) >> 2.
REQ-022 Bits [1:0] of the address SHALL be ignored; accesses are word-wide only.
REQ-023 A request is out of range if address < BASE or the word index >= DEPTH; subtraction is 32-bit unsigned with borrow detection.
REQ-024 Valid load: valueOut SHALL equal the addressed word during the RESPOND cycle and hold until the next response.
REQ-025 Valid store: the latched value SHALL be written at the end of the RESPOND cycle; valueOut is unchanged.
REQ-026 Out-of-range load: valueOut = 0 and errorOut = 1 in RESPOND.
REQ-027 Out-of-range store: no write and errorOut = 1 in RESPOND.
REQ-028 loadIn and storeIn both high at acceptance: SHALL be rejected with no write, valueOut = 0 and errorOut = 1.
REQ-029 A load immediately following a store to the same word SHALL return the stored value.

Reset
REQ-030 resetIn high SHALL force state IDLE, counter 0, readyOut 0, errorOut 0 and valueOut 0 at the next rising edge.
REQ-031 Reset in BUSY or RESPOND SHALL abandon the access: no write, no readyOut pulse.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 A request present in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-034 Shared package memory_package SHALL hold the state enum typedef (IDLE/BUSY/RESPOND), WORD_WIDTH=32 and the LATENCY counter width constant (4).
REQ-035 Storage SHALL be a sub-module memory_array: single-port synchronous RAM with DEPTH words, one read or write per cycle and one-cycle read latency; its read SHALL be issued so that data lands in RESPOND.
REQ-036 The FSM, counter, range check and output registers SHALL live in memory_responder.

Verification
REQ-037 Reset, LATENCY=2, BASE=0: store 0xDEADBEEF to 0x10 -> readyOut 2 cycles after acceptance, errorOut 0; then load 0x10 -> valueOut 0xDEADBEEF with readyOut.
REQ-038 LATENCY=1: store to 0x0, then a back-to-back load of 0x0 in the cycle after ready -> accepted immediately, ready next cycle, returns the stored value.
REQ-039 DEPTH=1024, BASE=0x1000: load 0x0FFC and load 0x2000 -> each gives errorOut=1 and valueOut=0; store to 0x2000 -> errorOut=1, and a later load of 0x1FFC is unchanged.
REQ-040 loadIn=storeIn=1 at 0x20 with value 0x12345678 -> errorOut=1, valueOut=0; a later load of 0x20 returns the prior contents.
REQ-041 Store 0xCAFEF00D to 0x30, assert resetIn in the BUSY cycle -> no readyOut; after reset, load 0x30 returns the old value; a request in the first post-reset cycle completes normally.
REQ-042 Load 0x33 after a store of 0xA5A5A5A5 to 0x30 -> returns 0xA5A5A5A5 (low address bits ignored).
